// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data widths, fetch FSM states and PC helpers.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    // Fetch unit control states.
    typedef enum logic {
        FETCH,
        FLUSH
    } fetch_state_e;

    // Address of the instruction n words before pc (modulo 2^XLEN).
    function automatic logic [XLEN-1:0] pc_rewind(input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] n);
        return pc - (n << 2);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO holding fetched {pc, instruction} pairs.
// Flush empties the FIFO and overrides any same-cycle push or pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 96
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign count     = cnt_q;
    assign head_data = mem_q[rd_q];
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push   = push & (~full | pop);
    assign do_pop    = pop & ~empty;

    // Entry storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_q] <= push_data;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_inc(wr_q);
            if (do_pop)  rd_q <= ptr_inc(rd_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: sequential instruction fetch with a credit-limited request stream,
// an in-order response buffer and redirect/flush handling.
// Build option: IFETCH_MISALIGN_CHECK_EN -- flag redirect targets with pc[1:0] != 0 and
// stall fetching until an aligned redirect; otherwise targets are silently word-aligned.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 64'h0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_err
);
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SW = CW + 1;
    localparam int unsigned EW = XLEN + ILEN;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   buf_count;
    logic            buf_full, buf_empty;
    logic [EW-1:0]   buf_head;
    logic [SW-1:0]   inflight;
    logic [XLEN-1:0] redirect_tgt;
    logic [XLEN-1:0] rsp_pc;
    logic            req_fire, push_en, pop_en;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic mis_q;

    // Error follows the alignment of the most recent redirect target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_q <= 1'b0;
        end else if (redirect_valid) begin
            mis_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign misalign_err = mis_q;
    assign redirect_tgt = redirect_pc;
`else
    assign misalign_err = 1'b0;
    assign redirect_tgt = redirect_pc & ~XLEN'(3);
`endif

    // Outstanding requests in FETCH are consecutive words ending just below pc_q,
    // so the oldest one (the responding one) sits out_q words back.
    assign rsp_pc   = pc_rewind(pc_q, XLEN'(out_q));
    assign req_fire = imem_req_valid & imem_req_ready;
    // Redirect wins over pop and push in the same cycle.
    assign pop_en   = inst_valid & inst_ready & ~redirect_valid;
    assign push_en  = imem_rsp_valid & (state_q == FETCH) & ~redirect_valid;

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push_en),
        .push_data ({rsp_pc, imem_rsp_data}),
        .pop       (pop_en),
        .head_data (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // Next-state for FSM, fetch pc and outstanding count; request valid.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        out_d          = out_q;
        inflight       = SW'(out_q) + SW'(buf_count);
        // rst_n gating keeps the request low while reset is held.
        imem_req_valid = rst_n & (state_q == FETCH) & ~misalign_err &
                         (inflight < SW'(BUF_DEPTH));

        case ({req_fire, imem_rsp_valid})
            2'b10:   out_d = out_q + 1'b1;
            2'b01:   out_d = out_q - 1'b1;
            default: out_d = out_q;
        endcase

        if (redirect_valid) begin
            // Everything still in flight, including a request accepted now, is stale.
            pc_d    = redirect_tgt;
            state_d = (out_d != '0) ? FLUSH : FETCH;
        end else begin
            if (req_fire) pc_d = pc_q + XLEN'(4);
            if (state_q == FLUSH && out_d == '0) state_d = FETCH;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
        end
    end

    assign imem_req_addr = pc_q;
    assign inst_valid    = ~buf_empty;
    assign inst          = inst_valid ? buf_head[ILEN-1:0] : '0;
    assign inst_pc       = inst_valid ? buf_head[EW-1:ILEN] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic, checked every cycle against
// a queue-based model of the fetch unit and a behavioural instruction memory.
module tb_instr_fetch;
    localparam int unsigned DEPTH = 2;
    localparam logic [63:0] RPC   = 64'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        misalign_err;

    instr_fetch #(
        .RESET_PC  (RPC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_due = -1;
    int n_fire   = 0;

    // Model: next fetch address, in-flight request addresses (oldest first) with their
    // response cycles, how many of the oldest in-flight ones are stale, buffered pcs.
    logic [63:0] m_pc;
    logic [63:0] m_out[$];
    int          mem_due[$];
    int          m_stale;
    logic [63:0] m_buf[$];
    bit          m_mis;

    function automatic logic [31:0] memword(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    function automatic bit model_req();
        return !m_mis && (m_stale == 0) && (m_out.size() + m_buf.size() < int'(DEPTH));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        m_out.delete();
        mem_due.delete();
        m_buf.delete();
        m_stale  = 0;
        m_pc     = RPC;
        m_mis    = 1'b0;
        last_due = -1;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'h0);
        chk("rst_inst_valid", 64'(inst_valid), 64'h0);
        chk("rst_inst", 64'(inst), 64'h0);
        chk("rst_inst_pc", inst_pc, 64'h0);
        chk("rst_misalign", 64'(misalign_err), 64'h0);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare outputs against the model, advance the model.
    task automatic run_cycle(input bit rdy, input bit irdy, input bit redir,
                             input logic [63:0] rpc, input int dly);
        bit          mreq, fire, do_pop, rsp;
        logic [63:0] rp;
        int          due;
        @(negedge clk);
        rsp = (mem_due.size() > 0) && (mem_due[0] <= cyc);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memword(m_out[0]) : 32'h0;
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = rpc;

        mreq = model_req();
        chk("req_valid", 64'(imem_req_valid), 64'(mreq));
        if (mreq) chk("req_addr", imem_req_addr, m_pc);
        chk("inst_valid", 64'(inst_valid), 64'(m_buf.size() > 0));
        if (m_buf.size() > 0) begin
            chk("inst_pc", inst_pc, m_buf[0]);
            chk("inst", 64'(inst), 64'(memword(m_buf[0])));
        end
        chk("misalign_err", 64'(misalign_err), 64'(m_mis));
        if (imem_req_valid && rdy) n_fire++;

        fire   = mreq && rdy;
        do_pop = (m_buf.size() > 0) && irdy;
        due    = cyc + dly;
        if (due <= last_due) due = last_due + 1;
        rp = '0;
        if (rsp) begin
            rp = m_out.pop_front();
            void'(mem_due.pop_front());
        end
        if (redir) begin
            if (fire) begin
                m_out.push_back(m_pc);
                mem_due.push_back(due);
                last_due = due;
            end
            m_stale = m_out.size();
            m_buf.delete();
`ifdef IFETCH_MISALIGN_CHECK_EN
            m_pc  = rpc;
            m_mis = (rpc[1:0] != 2'b00);
`else
            m_pc  = {rpc[63:2], 2'b00};
`endif
        end else begin
            if (do_pop) void'(m_buf.pop_front());
            if (rsp) begin
                if (m_stale > 0) m_stale--;
                else m_buf.push_back(rp);
            end
            if (fire) begin
                m_out.push_back(m_pc);
                mem_due.push_back(due);
                last_due = due;
                m_pc     = m_pc + 64'd4;
            end
        end
        cyc++;
    endtask

    // Run with everything ready until inst_valid shows, then pin its pc.
    task automatic wait_inst(input string name, input logic [63:0] exp_pc);
        bit found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
            if (inst_valid) begin
                found = 1'b1;
                chk(name, inst_pc, exp_pc);
            end
        end
        if (!found) chk({name, "_timeout"}, 64'h0, 64'h1);
    endtask

    initial begin
        bit          rdy, irdy, redir;
        logic [63:0] rpc;

        // Straight-line fetch with a 1-cycle memory.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
            if (i == 0) begin
                chk("a_first_valid", 64'(imem_req_valid), 64'h1);
                chk("a_first_addr", imem_req_addr, 64'h0);
            end
            if (i == 1) begin
                chk("a_second_addr", imem_req_addr, 64'h4);
                chk("a_no_inst_yet", 64'(inst_valid), 64'h0);
            end
            if (i == 2) begin
                chk("a_first_inst_valid", 64'(inst_valid), 64'h1);
                chk("a_first_inst_pc", inst_pc, 64'h0);
                chk("a_first_inst", 64'(inst), 64'h0BAD_F00D);
            end
        end

        // Decode stalled: request stream stops at buffer depth, then drains in order.
        do_reset();
        n_fire = 0;
        repeat (10) run_cycle(1'b1, 1'b0, 1'b0, 64'h0, 1);
        chk("b_fires", 64'(n_fire), 64'(DEPTH));
        chk("b_req_low", 64'(imem_req_valid), 64'h0);
        chk("b_buf_valid", 64'(inst_valid), 64'h1);
        chk("b_head_pc", inst_pc, 64'h0);
        repeat (12) run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);

        // Redirect with two requests outstanding.
        do_reset();
        run_cycle(1'b0, 1'b0, 1'b1, 64'h10, 1);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 3);
        chk("c_addr_10", imem_req_addr, 64'h10);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 3);
        chk("c_addr_14", imem_req_addr, 64'h14);
        run_cycle(1'b0, 1'b1, 1'b1, 64'h100, 1);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("c_flush_req0", 64'(imem_req_valid), 64'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("c_flush_req1", 64'(imem_req_valid), 64'h0);
        chk("c_flush_inst", 64'(inst_valid), 64'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("c_resume_addr", imem_req_addr, 64'h100);
        wait_inst("c_first_pc", 64'h100);

        // Redirect colliding with a pop and an accepted request.
        do_reset();
        run_cycle(1'b1, 1'b0, 1'b0, 64'h0, 1);
        run_cycle(1'b0, 1'b0, 1'b0, 64'h0, 1);
        run_cycle(1'b1, 1'b1, 1'b1, 64'h40, 1);
        chk("d_req_at_redirect", 64'(imem_req_valid), 64'h1);
        chk("d_inst_at_redirect", 64'(inst_valid), 64'h1);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("d_inst_low_after", 64'(inst_valid), 64'h0);
        chk("d_req_low_flush", 64'(imem_req_valid), 64'h0);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("d_resume_addr", imem_req_addr, 64'h40);
        wait_inst("d_first_pc", 64'h40);

        // Fetch address wraps past the top of the address space.
        do_reset();
        run_cycle(1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("e_addr_fff8", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("e_addr_fffc", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 10 && !seen; i++) begin
                run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
                if (imem_req_valid) begin
                    seen = 1'b1;
                    chk("e_wrap_addr", imem_req_addr, 64'h0);
                end
            end
            if (!seen) chk("e_wrap_timeout", 64'h0, 64'h1);
        end

        // Misaligned redirect target.
        do_reset();
        run_cycle(1'b0, 1'b1, 1'b1, 64'h102, 1);
`ifdef IFETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
            chk("f_mis_set", 64'(misalign_err), 64'h1);
            chk("f_mis_no_req", 64'(imem_req_valid), 64'h0);
        end
        run_cycle(1'b0, 1'b1, 1'b1, 64'h200, 1);
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("f_mis_clear", 64'(misalign_err), 64'h0);
        chk("f_resume_valid", 64'(imem_req_valid), 64'h1);
        chk("f_resume_addr", imem_req_addr, 64'h200);
`else
        run_cycle(1'b1, 1'b1, 1'b0, 64'h0, 1);
        chk("f_mis_tied", 64'(misalign_err), 64'h0);
        chk("f_aligned_valid", 64'(imem_req_valid), 64'h1);
        chk("f_aligned_addr", imem_req_addr, 64'h100);
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rdy   = ($urandom_range(0, 99) < 70);
            irdy  = ($urandom_range(0, 99) < 70);
            redir = ($urandom_range(0, 99) < 4);
            rpc   = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) rpc[63:8] = '1;
            run_cycle(rdy, irdy, redir, rpc, int'($urandom_range(1, 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
